// File: rtl/tilelink_sram_responder.sv
// TileLink-UL/UH slave backed by a word-addressed SRAM: Get, PutFullData and,
// with TLSRAM_PARTIAL_EN defined, PutPartialData; single-beat or 32-bit bursts.
module tilelink_sram_responder #(
  parameter int               TL_AW       = 32,
  parameter logic [TL_AW-1:0] BASE_ADDR   = '0,
  parameter int               DEPTH_WORDS = 1024
) (
  input  logic             tlsram_clock_i,
  input  logic             tlsram_reset_ni,
  input  logic [2:0]       tlsram_a_opcode,
  input  logic [2:0]       tlsram_a_param,
  input  logic [3:0]       tlsram_a_size,
  input  logic [TL_AW-1:0] tlsram_a_address,
  input  logic [3:0]       tlsram_a_mask,
  input  logic [31:0]      tlsram_a_data,
  input  logic             tlsram_a_corrupt,
  input  logic             tlsram_a_valid,
  output logic             tlsram_a_ready,
  output logic [2:0]       tlsram_d_opcode,
  output logic [1:0]       tlsram_d_param,
  output logic [3:0]       tlsram_d_size,
  output logic             tlsram_d_denied,
  output logic [31:0]      tlsram_d_data,
  output logic             tlsram_d_corrupt,
  output logic             tlsram_d_valid,
  input  logic             tlsram_d_ready
);

  localparam int             IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [TL_AW:0] SPAN  = (TL_AW+1)'(4 * DEPTH_WORDS);
  localparam logic [2:0]     OP_ACK      = 3'd0;
  localparam logic [2:0]     OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, RESP} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             denied_q, denied_d;
  logic             d_valid_q, d_valid_d;
  logic [2:0]       d_opcode_q, d_opcode_d;
  logic [3:0]       d_size_q, d_size_d;
  logic             d_denied_q, d_denied_d;
  logic [31:0]      d_data_q, d_data_d;
  logic             d_corrupt_q, d_corrupt_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;

  logic [TL_AW:0]   off_ext, size_bytes, end_ext;
  logic             misalign, op_ok, a_denied, a_ready_c, d_hs;
  logic [4:0]       beats_m1;
  logic [IDX_W-1:0] a_idx;

  // First-beat decode; off_ext carries a borrow bit so addresses below BASE_ADDR show up as huge.
  always_comb begin
    off_ext    = {1'b0, tlsram_a_address} - {1'b0, BASE_ADDR};
    size_bytes = (TL_AW+1)'(1) << tlsram_a_size;
    end_ext    = off_ext + size_bytes;
    misalign   = |(tlsram_a_address & (size_bytes[TL_AW-1:0] - TL_AW'(1)));
`ifdef TLSRAM_PARTIAL_EN
    op_ok      = tlsram_a_opcode inside {3'd0, 3'd1, 3'd4};
`else
    op_ok      = tlsram_a_opcode inside {3'd0, 3'd4};
`endif
    a_denied   = (tlsram_a_size > 4'd7) | off_ext[TL_AW] | (off_ext >= SPAN) |
                 (end_ext > SPAN) | misalign | !op_ok;
    case (tlsram_a_size)
      4'd3:    beats_m1 = 5'd1;
      4'd4:    beats_m1 = 5'd3;
      4'd5:    beats_m1 = 5'd7;
      4'd6:    beats_m1 = 5'd15;
      4'd7:    beats_m1 = 5'd31;
      default: beats_m1 = 5'd0;
    endcase
  end

  assign a_idx = off_ext[IDX_W+1:2];
  assign d_hs  = d_valid_q & tlsram_d_ready;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    denied_d    = denied_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_denied_d  = d_denied_q;
    d_data_d    = d_data_q;
    d_corrupt_d = d_corrupt_q;
    mem_we      = 1'b0;
    mem_widx    = idx_q;
    a_ready_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        a_ready_c = 1'b1;
        if (tlsram_a_valid) begin
          d_size_d = tlsram_a_size;
          idx_d    = a_idx + IDX_W'(1);
          denied_d = a_denied;
          cnt_d    = beats_m1;
          if (tlsram_a_opcode[2]) begin
            state_d     = READ_BURST;
            d_valid_d   = 1'b1;
            d_opcode_d  = OP_ACK_DATA;
            d_denied_d  = a_denied;
            d_corrupt_d = a_denied;
            d_data_d    = a_denied ? 32'h0 : mem[a_idx];
          end else begin
            mem_widx = a_idx;
            mem_we   = !a_denied && !tlsram_a_corrupt;
            if (beats_m1 == 5'd0) begin
              state_d     = RESP;
              d_valid_d   = 1'b1;
              d_opcode_d  = OP_ACK;
              d_denied_d  = a_denied;
              d_corrupt_d = 1'b0;
              d_data_d    = 32'h0;
            end else begin
              state_d = WRITE_BURST;
            end
          end
        end
      end
      READ_BURST: begin
        if (d_hs) begin
          if (cnt_q == 5'd0) begin
            state_d   = IDLE;
            d_valid_d = 1'b0;
          end else begin
            d_data_d = denied_q ? 32'h0 : mem[idx_q];
            idx_d    = idx_q + IDX_W'(1);
            cnt_d    = cnt_q - 5'd1;
          end
        end
      end
      WRITE_BURST: begin
        a_ready_c = 1'b1;
        if (tlsram_a_valid) begin
          mem_we = !denied_q && !tlsram_a_corrupt;
          idx_d  = idx_q + IDX_W'(1);
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d     = RESP;
            d_valid_d   = 1'b1;
            d_opcode_d  = OP_ACK;
            d_denied_d  = denied_q;
            d_corrupt_d = 1'b0;
            d_data_d    = 32'h0;
          end
        end
      end
      RESP: begin
        if (d_hs) begin
          state_d   = IDLE;
          d_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tlsram_clock_i or negedge tlsram_reset_ni) begin
    if (!tlsram_reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      denied_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      denied_q    <= denied_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_denied_q  <= d_denied_d;
      d_data_q    <= d_data_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  // NOTE: the array has no reset so it maps onto SRAM and its contents survive a bus reset.
  always_ff @(posedge tlsram_clock_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && tlsram_a_mask[b]) mem[mem_widx][8*b +: 8] <= tlsram_a_data[8*b +: 8];
    end
  end

  assign tlsram_a_ready   = a_ready_c & tlsram_reset_ni;
  assign tlsram_d_valid   = d_valid_q;
  assign tlsram_d_opcode  = d_opcode_q;
  assign tlsram_d_param   = 2'b00;
  assign tlsram_d_size    = d_size_q;
  assign tlsram_d_denied  = d_denied_q;
  assign tlsram_d_data    = d_data_q;
  assign tlsram_d_corrupt = d_corrupt_q;

  logic unused_a_param;
  assign unused_a_param = ^tlsram_a_param;

endmodule

// File: tb/tb_tilelink_sram_responder.sv
// Self-checking bench for tilelink_sram_responder: directed and random Put/Get
// traffic compared against a word-array reference model of the TileLink rules.
module tb_tilelink_sram_responder;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 1024;
`ifdef TLSRAM_PARTIAL_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [31:0] a_address, a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0] d_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] wdata_q [$];
  logic [3:0]  wmask_q [$];
  bit          wcorr_q [$];

  always #5 clk = ~clk;

  tilelink_sram_responder #(.TL_AW(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .tlsram_clock_i   (clk),
    .tlsram_reset_ni  (rst_n),
    .tlsram_a_opcode  (a_opcode),
    .tlsram_a_param   (a_param),
    .tlsram_a_size    (a_size),
    .tlsram_a_address (a_address),
    .tlsram_a_mask    (a_mask),
    .tlsram_a_data    (a_data),
    .tlsram_a_corrupt (a_corrupt),
    .tlsram_a_valid   (a_valid),
    .tlsram_a_ready   (a_ready),
    .tlsram_d_opcode  (d_opcode),
    .tlsram_d_param   (d_param),
    .tlsram_d_size    (d_size),
    .tlsram_d_denied  (d_denied),
    .tlsram_d_data    (d_data),
    .tlsram_d_corrupt (d_corrupt),
    .tlsram_d_valid   (d_valid),
    .tlsram_d_ready   (d_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_deny(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr);
    longint off, bytes;
    bit op_ok;
    off   = longint'(addr) - longint'(BASE);
    bytes = longint'(1) << size;
    op_ok = (op == 3'd0) || (op == 3'd4) || (PARTIAL && op == 3'd1);
    return !op_ok || size > 4'd7 || off < 0 || off + bytes > 4 * DEPTH ||
           (longint'(addr) % bytes) != 0;
  endfunction

  function automatic int beats_of(input logic [3:0] size);
    return (size <= 4'd2) ? 1 : (1 << (int'(size) - 2));
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  function automatic void model_write(input int w, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] cur;
    cur = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
    for (int b = 0; b < 4; b++) if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
    ref_mem[w] = cur;
  endfunction

  // One A beat: present it after a rising edge, wait for a_ready, handshake on the next edge.
  task automatic a_send(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input logic corr,
                        input string tag);
    int n;
    @(posedge clk); #1;
    a_opcode = op; a_size = size; a_address = addr; a_data = data;
    a_mask = mask; a_corrupt = corr; a_param = 3'($urandom_range(0, 7)); a_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin n++; @(negedge clk); end
    if (!a_ready) check({tag, " a_ready timeout"}, a_ready, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic do_put(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                        input string tag);
    bit deny;
    int w0;
    deny = model_deny(op, size, addr);
    w0   = deny ? 0 : word_of(addr);
    for (int k = 0; k < wdata_q.size(); k++) begin
      a_send(op, size, addr, wdata_q[k], wmask_q[k], wcorr_q[k], tag);
      if (!deny && !wcorr_q[k]) model_write(w0 + k, wdata_q[k], wmask_q[k]);
    end
    @(negedge clk);
    check({tag, " ack valid"}, d_valid, 1'b1);
    check({tag, " ack opcode"}, d_opcode, 3'd0);
    check({tag, " ack denied"}, d_denied, deny);
    check({tag, " ack corrupt"}, d_corrupt, 1'b0);
    check({tag, " ack size"}, d_size, size);
    check({tag, " a_ready in resp"}, a_ready, 1'b0);
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    @(negedge clk);
    check({tag, " ack retired"}, d_valid, 1'b0);
    wdata_q.delete(); wmask_q.delete(); wcorr_q.delete();
  endtask

  task automatic do_get(input logic [3:0] size, input logic [31:0] addr, input bit toggle,
                        input string tag);
    bit deny, stalled;
    int beats, w0, got, cyc;
    logic [31:0] held, expd;
    deny  = model_deny(3'd4, size, addr);
    beats = deny && size > 4'd7 ? 1 : beats_of(size);
    w0    = deny ? 0 : word_of(addr);
    a_send(3'd4, size, addr, 32'h0, 4'h0, 1'b0, tag);
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < beats && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) check({tag, " first-beat latency"}, d_valid, 1'b1);
      if (!toggle) check({tag, " back-to-back beat"}, d_valid, 1'b1);
      check({tag, " a_ready low"}, a_ready, 1'b0);
      if (stalled) begin
        check({tag, " held valid"}, d_valid, 1'b1);
        check({tag, " held data"}, d_data, held);
      end
      if (d_valid) begin
        d_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
        if (d_ready) begin
          check({tag, " opcode"}, d_opcode, 3'd1);
          check({tag, " size"}, d_size, size);
          check({tag, " denied"}, d_denied, deny);
          check({tag, " corrupt"}, d_corrupt, deny);
          if (deny) check({tag, " data"}, d_data, 32'h0);
          else if (ref_mem.exists(w0 + got) && !$isunknown(ref_mem[w0 + got])) begin
            expd = ref_mem[w0 + got];
            check({tag, " data"}, d_data, expd);
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = d_data;
        end
      end else begin
        d_ready = 1'b0;
      end
      cyc++;
    end
    if (got < beats) check({tag, " beat count"}, got, beats);
    @(negedge clk);
    check({tag, " no extra beat"}, d_valid, 1'b0);
    check({tag, " re-accept"}, a_ready, 1'b1);
    d_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rsize;
    logic [31:0] raddr;
    int          rbytes, roff, sel, w0;
    rst_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset a_ready", a_ready, 1'b0);
    check("reset d_valid", d_valid, 1'b0);
    check("reset d_opcode", d_opcode, 3'd0);
    check("reset d_param", d_param, 2'd0);
    check("reset d_size", d_size, 4'd0);
    check("reset d_denied", d_denied, 1'b0);
    check("reset d_data", d_data, 32'h0);
    check("reset d_corrupt", d_corrupt, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle a_ready", a_ready, 1'b1);

    wdata_q.push_back(32'hDEAD_BEEF); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    do_put(3'd0, 4'd2, BASE + 32'h10, "put word");
    do_get(4'd2, BASE + 32'h10, 1'b0, "get word");

    for (int i = 0; i < 32; i++) begin
      wdata_q.push_back(32'(i)); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    end
    do_put(3'd0, 4'd7, BASE + 32'h80, "put 128B");
    do_get(4'd7, BASE + 32'h80, 1'b0, "get 128B");
    do_get(4'd6, BASE + 32'h80, 1'b1, "get 64B toggle");

    do_get(4'd2, BASE + 32'(4 * DEPTH), 1'b0, "get past end");
    do_get(4'd3, BASE + 32'h4, 1'b0, "get misaligned");
    do_get(4'd2, BASE - 32'h4, 1'b0, "get below base");

    wdata_q.push_back(32'h1122_3344); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    do_put(3'd0, 4'd2, BASE + 32'h40, "preload partial");
    wdata_q.push_back(32'hAABB_CCDD); wmask_q.push_back(4'b0010); wcorr_q.push_back(1'b0);
    do_put(3'd1, 4'd2, BASE + 32'h40, "put partial");
    do_get(4'd2, BASE + 32'h40, 1'b0, "get partial");
    check("partial result", d_data, PARTIAL ? 32'h1122_CC44 : 32'h1122_3344);

    do_get(4'd0, BASE + 32'h13, 1'b0, "get byte");

    wdata_q.push_back(32'h0); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    do_put(3'd2, 4'd2, BASE + 32'h10, "bad opcode");
    do_get(4'd2, BASE + 32'h10, 1'b0, "get after bad opcode");

    wdata_q.push_back(32'h5555_0000); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    wdata_q.push_back(32'h5555_0001); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    do_put(3'd0, 4'd3, BASE + 32'(4 * DEPTH - 8) + 32'h8, "put past end");

    for (int i = 0; i < 4; i++) begin
      wdata_q.push_back(32'hA0A0_0000 + 32'(i)); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    end
    do_put(3'd0, 4'd4, BASE + 32'h300, "preload corrupt");
    for (int i = 0; i < 4; i++) begin
      wdata_q.push_back(32'hC0C0_0000 + 32'(i)); wmask_q.push_back(4'(4'hF >> i));
      wcorr_q.push_back(i == 1);
    end
    do_put(3'd0, 4'd4, BASE + 32'h300, "put corrupt beat");
    do_get(4'd4, BASE + 32'h300, 1'b1, "get corrupt burst");

    for (int it = 0; it < 24; it++) begin
      rsize  = 4'($urandom_range(0, 5));
      rbytes = 1 << rsize;
      roff   = int'($urandom_range(0, 4 * DEPTH / rbytes - 1)) * rbytes;
      sel    = int'($urandom_range(0, 5));
      raddr  = (sel == 0) ? BASE + 32'(4 * DEPTH + roff) :
               (sel == 1) ? BASE - 32'(rbytes) : BASE + 32'(roff);
      for (int k = 0; k < beats_of(rsize); k++) begin
        wdata_q.push_back($urandom); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
      end
      do_put(3'd0, rsize, raddr, "rand put");
      do_get(rsize, raddr, it[0], "rand get");
    end

    for (int i = 0; i < 16; i++) begin
      wdata_q.push_back(32'hBEE0_0000 + 32'(i)); wmask_q.push_back(4'hF); wcorr_q.push_back(1'b0);
    end
    do_put(3'd0, 4'd6, BASE + 32'h200, "preload reset");
    w0 = word_of(BASE + 32'h200);
    a_send(3'd4, 4'd6, BASE + 32'h200, 32'h0, 4'h0, 1'b0, "reset get");
    d_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("mid-burst beat 5 valid", d_valid, 1'b1);
    check("mid-burst beat 5 data", d_data, ref_mem[w0 + 4]);
    rst_n = 1'b0;
    #1;
    check("async reset d_valid", d_valid, 1'b0);
    check("async reset a_ready", a_ready, 1'b0);
    d_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_get(4'd6, BASE + 32'h200, 1'b0, "get after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
